// File: rtl/seg_scan_capture.sv
// Multiplexed 7-segment scan reader: syncs seg/key0, captures settled digits, publishes 4-digit frames.
// Optional build macro SEG_CAPTURE_HEX_EN enables decoding of hex digits A-F.
module seg_scan_capture #(
   parameter int unsigned SETTLE = 16
) (
   input  logic        clk_50mhz,
   input  logic        rst,
   input  logic [6:0]  seg,
   input  logic [3:0]  key0,
   output logic [15:0] digits,
   output logic [3:0]  blank,
   output logic        frame_valid,
   output logic        pattern_err
);

   localparam int unsigned CW = $clog2(SETTLE + 1);

   logic [6:0]    seg_m, s_seg, prev_seg;
   logic [3:0]    key_m, s_key, prev_key;
   logic [CW-1:0] cnt;
   logic [3:0]    seen;
   logic [15:0]   shadow_d;
   logic [3:0]    shadow_b;

   logic          sel_ok;
   logic [1:0]    idx;
   logic          stable;
   logic          capture_c;
   logic [5:0]    dec;
   logic          cap_ok;

   // Returns {decodable, blank, value}
   function automatic logic [5:0] decode(input logic [6:0] p);
      logic [5:0] r;
      r = 6'b0_0_0000;
      case (p)
         7'h40: r = {2'b10, 4'h0};
         7'h79: r = {2'b10, 4'h1};
         7'h24: r = {2'b10, 4'h2};
         7'h30: r = {2'b10, 4'h3};
         7'h19: r = {2'b10, 4'h4};
         7'h12: r = {2'b10, 4'h5};
         7'h02: r = {2'b10, 4'h6};
         7'h78: r = {2'b10, 4'h7};
         7'h00: r = {2'b10, 4'h8};
         7'h10: r = {2'b10, 4'h9};
`ifdef SEG_CAPTURE_HEX_EN
         7'h08: r = {2'b10, 4'hA};
         7'h03: r = {2'b10, 4'hB};
         7'h46: r = {2'b10, 4'hC};
         7'h21: r = {2'b10, 4'hD};
         7'h06: r = {2'b10, 4'hE};
         7'h0E: r = {2'b10, 4'hF};
`endif
         7'h7F: r = {2'b11, 4'h0};
         default: r = 6'b0_0_0000;
      endcase
      return r;
   endfunction

   // Input must agree across both synchronizer stages and the previous cycle,
   // so a dwell needs SETTLE+2 cycles at the pins before it is captured.
   always_comb begin
      sel_ok = 1'b1;
      idx    = 2'd0;
      case (s_key)
         4'b1110: idx = 2'd0;
         4'b1101: idx = 2'd1;
         4'b1011: idx = 2'd2;
         4'b0111: idx = 2'd3;
         default: sel_ok = 1'b0;
      endcase
      stable    = (seg_m == s_seg) && (key_m == s_key) &&
                  (s_seg == prev_seg) && (s_key == prev_key);
      capture_c = sel_ok && stable && (cnt == CW'(SETTLE - 1));
      dec       = decode(s_seg);
      cap_ok    = capture_c && dec[5];
   end

   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         seg_m    <= 7'h7F;
         s_seg    <= 7'h7F;
         prev_seg <= 7'h7F;
         key_m    <= 4'hF;
         s_key    <= 4'hF;
         prev_key <= 4'hF;
         cnt      <= '0;
      end else begin
         seg_m    <= seg;
         s_seg    <= seg_m;
         prev_seg <= s_seg;
         key_m    <= key0;
         s_key    <= key_m;
         prev_key <= s_key;
         if (!sel_ok || !stable)
            cnt <= '0;
         else if (cnt != CW'(SETTLE))
            cnt <= cnt + CW'(1);
      end
   end

   // Completion clears seen before a same-edge capture is merged into the next frame
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         seen        <= 4'h0;
         shadow_d    <= 16'h0000;
         shadow_b    <= 4'h0;
         digits      <= 16'h0000;
         blank       <= 4'hF;
         frame_valid <= 1'b0;
         pattern_err <= 1'b0;
      end else begin
         frame_valid <= (seen == 4'hF);
         pattern_err <= capture_c && !dec[5];
         if (seen == 4'hF) begin
            digits <= shadow_d;
            blank  <= shadow_b;
         end
         seen <= ((seen == 4'hF) ? 4'h0 : seen) | (cap_ok ? (4'b0001 << idx) : 4'h0);
         if (cap_ok) begin
            shadow_d[4*idx +: 4] <= dec[3:0];
            shadow_b[idx]        <= dec[4];
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Directed bench for seg_scan_capture (SETTLE=16); expectations follow SEG_CAPTURE_HEX_EN when defined.
module tb_seg_scan_capture;

   logic        clk_50mhz = 1'b0;
   logic        rst;
   logic [6:0]  seg;
   logic [3:0]  key0;
   logic [15:0] digits;
   logic [3:0]  blank;
   logic        frame_valid;
   logic        pattern_err;

   int n_chk  = 0;
   int n_pass = 0;
   int cyc    = 0;
   int fv_cnt = 0;
   int pe_cnt = 0;
   int fv_cyc = 0;
   int pe_cyc = 0;
   int fv0, pe0, t0;

   seg_scan_capture #(.SETTLE(16)) dut (
      .clk_50mhz   (clk_50mhz),
      .rst         (rst),
      .seg         (seg),
      .key0        (key0),
      .digits      (digits),
      .blank       (blank),
      .frame_valid (frame_valid),
      .pattern_err (pattern_err)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   always @(posedge clk_50mhz) cyc <= cyc + 1;

   // Pulse monitor, sampled away from the active edge
   always @(negedge clk_50mhz) begin
      if (frame_valid) begin
         fv_cnt <= fv_cnt + 1;
         fv_cyc <= cyc;
      end
      if (pattern_err) begin
         pe_cnt <= pe_cnt + 1;
         pe_cyc <= cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic dwell(input logic [3:0] k, input logic [6:0] s, input int n);
      key0 = k;
      seg  = s;
      repeat (n) @(negedge clk_50mhz);
   endtask

   initial begin
      rst  = 1'b1;
      seg  = 7'h7F;
      key0 = 4'hF;
      repeat (3) @(negedge clk_50mhz);
      rst = 1'b0;

      // Idle bus
      dwell(4'hF, 7'h7F, 100);
      chk("idle_digits", 32'(digits), 32'h0000);
      chk("idle_blank", 32'(blank), 32'hF);
      chk("idle_fv", 32'(fv_cnt), 0);
      chk("idle_pe", 32'(pe_cnt), 0);

      // Full scan 1,2,3,4
      fv0 = fv_cnt;
      dwell(4'hE, 7'h79, 40);
      dwell(4'hD, 7'h24, 40);
      dwell(4'hB, 7'h30, 40);
      t0 = cyc;
      dwell(4'h7, 7'h19, 40);
      dwell(4'hF, 7'h7F, 10);
      chk("scan_fv", 32'(fv_cnt - fv0), 1);
      chk("scan_fv_lat", 32'(fv_cyc - t0), 20);
      chk("scan_digits", 32'(digits), 32'h4321);
      chk("scan_blank", 32'(blank), 32'h0);

      // Digit 2 dwell of 17 is too short, 18 completes
      fv0 = fv_cnt;
      dwell(4'hE, 7'h12, 40);
      dwell(4'hD, 7'h02, 40);
      dwell(4'hB, 7'h78, 17);
      dwell(4'h7, 7'h00, 40);
      dwell(4'hF, 7'h7F, 10);
      chk("short17_fv", 32'(fv_cnt - fv0), 0);
      chk("short17_digits", 32'(digits), 32'h4321);
      dwell(4'hB, 7'h78, 18);
      dwell(4'hF, 7'h7F, 10);
      chk("dwell18_fv", 32'(fv_cnt - fv0), 1);
      chk("dwell18_digits", 32'(digits), 32'h8765);

      // Two selects low: never captured
      fv0 = fv_cnt;
      pe0 = pe_cnt;
      dwell(4'b1100, 7'h40, 100);
      dwell(4'hF, 7'h7F, 10);
      chk("multi_fv", 32'(fv_cnt - fv0), 0);
      chk("multi_pe", 32'(pe_cnt - pe0), 0);
      dwell(4'hE, 7'h79, 40);
      dwell(4'hD, 7'h24, 40);
      dwell(4'hB, 7'h30, 40);
      dwell(4'hF, 7'h7F, 10);
      chk("multi_no_d3", 32'(fv_cnt - fv0), 0);
      dwell(4'h7, 7'h19, 40);
      dwell(4'hF, 7'h7F, 10);
      chk("multi_then_d3", 32'(fv_cnt - fv0), 1);

      // Hex pattern on digit 0
      fv0 = fv_cnt;
      pe0 = pe_cnt;
      t0  = cyc;
      dwell(4'hE, 7'h08, 40);
      dwell(4'hD, 7'h79, 40);
      dwell(4'hB, 7'h24, 40);
      dwell(4'h7, 7'h30, 40);
      dwell(4'hF, 7'h7F, 10);
`ifdef SEG_CAPTURE_HEX_EN
      chk("hex_pe", 32'(pe_cnt - pe0), 0);
      chk("hex_fv", 32'(fv_cnt - fv0), 1);
      chk("hex_digits", 32'(digits), 32'h321A);
`else
      chk("hex_pe", 32'(pe_cnt - pe0), 1);
      chk("hex_pe_lat", 32'(pe_cyc - t0), 19);
      chk("hex_fv", 32'(fv_cnt - fv0), 0);
      dwell(4'hE, 7'h40, 40);
      dwell(4'hF, 7'h7F, 10);
      chk("hex_fill_fv", 32'(fv_cnt - fv0), 1);
      chk("hex_fill_digits", 32'(digits), 32'h3210);
`endif

      // Asynchronous reset after three digits
      dwell(4'hE, 7'h79, 40);
      dwell(4'hD, 7'h24, 40);
      dwell(4'hB, 7'h30, 40);
      dwell(4'hF, 7'h7F, 5);
      #3 rst = 1'b1;
      #1;
      chk("rst_digits", 32'(digits), 32'h0000);
      chk("rst_blank", 32'(blank), 32'hF);
      @(negedge clk_50mhz);
      rst = 1'b0;
      fv0 = fv_cnt;
      dwell(4'h7, 7'h79, 40);
      dwell(4'hF, 7'h7F, 10);
      chk("rst_partial_fv", 32'(fv_cnt - fv0), 0);
      dwell(4'hE, 7'h19, 40);
      dwell(4'hD, 7'h7F, 40);
      dwell(4'hB, 7'h40, 40);
      dwell(4'hF, 7'h7F, 10);
      chk("rst_full_fv", 32'(fv_cnt - fv0), 1);
      chk("rst_full_digits", 32'(digits), 32'h1004);
      chk("rst_full_blank", 32'(blank), 32'h2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
